// File: rtl/hqc_rmdecod_bytepack.sv
`default_nettype none
// ============================================================================
// Module      : hqc_rmdecod_bytepack
// Description : Packs decoded RM bytes little-endian into 64-bit words behind a
//               2-entry output FIFO. Optional checker: HQC_BYTEPACK_ERRCHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hqc_rmdecod_bytepack #(
    parameter int PARAM_SECURITY = 128,
    parameter int N1             = (PARAM_SECURITY == 256) ? 90 :
                                   (PARAM_SECURITY == 192) ? 56 : 46,
    parameter int DOUT_W         = 64,
    parameter int NWORDS         = (N1 + 7) / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        din_i,
    input  logic              din_valid_i,
    output logic [DOUT_W-1:0] dout_o,
    output logic [3:0]        dout_addr_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              done_o,
    output logic              err_o
);

    localparam int              c_BCW       = $clog2(N1);
    localparam logic [c_BCW-1:0] c_LAST_BYTE = c_BCW'(N1 - 1);
    localparam logic [3:0]       c_LAST_WORD = 4'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [2:0]         lane_q, lane_d;
    logic [3:0]         word_q, word_d;
    logic [DOUT_W-1:0]  pack_q, pack_d;
    logic               pend_vld_q, pend_vld_d;
    logic [DOUT_W-1:0]  pend_data_q, pend_data_d;
    logic [3:0]         pend_addr_q, pend_addr_d;
    logic [1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [DOUT_W-1:0]  head_data_q, head_data_d;
    logic [3:0]         head_addr_q, head_addr_d;
    logic [DOUT_W-1:0]  tail_data_q, tail_data_d;
    logic [3:0]         tail_addr_q, tail_addr_d;

    logic               w_accept;
    logic               w_last;
    logic               w_pop;
    logic               w_push;
    logic               w_done;
    logic [DOUT_W-1:0]  w_merged;
`ifdef HQC_BYTEPACK_ERRCHK_EN
    logic               w_ovf;
    logic               err_q, err_d;
`endif

    assign w_accept = (state_q == S_PACK) && din_valid_i && !start_i;
    assign w_last   = (byte_cnt_q == c_LAST_BYTE);
    assign w_merged = pack_q | (DOUT_W'(din_i) << {lane_q, 3'b000});
    assign w_pop    = (fifo_cnt_q != 2'd0) && dout_ready_i;
    assign w_push   = pend_vld_q;
    // A simultaneous start or reset aborts the message, so no completion pulse
    assign w_done   = w_pop && (state_q == S_FLUSH) && (head_addr_q == c_LAST_WORD)
                      && !start_i && !rst_i;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        lane_d      = lane_q;
        word_d      = word_q;
        pack_d      = pack_q;
        pend_vld_d  = 1'b0;
        pend_data_d = pend_data_q;
        pend_addr_d = pend_addr_q;

        if (start_i) begin
            state_d    = S_PACK;
            byte_cnt_d = '0;
            lane_d     = 3'd0;
            word_d     = 4'd0;
            pack_d     = '0;
        end else begin
            if (w_accept) begin
                if (lane_q == 3'd7 || w_last) begin
                    pend_vld_d  = 1'b1;
                    pend_data_d = w_merged;
                    pend_addr_d = word_q;
                    pack_d      = '0;
                    lane_d      = 3'd0;
                    word_d      = w_last ? 4'd0 : word_q + 4'd1;
                end else begin
                    pack_d = w_merged;
                    lane_d = lane_q + 3'd1;
                end
                byte_cnt_d = w_last ? '0 : byte_cnt_q + c_BCW'(1);
                if (w_last) begin
                    state_d = S_FLUSH;
                end
            end
            if (state_q == S_FLUSH && w_done) begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        fifo_cnt_d  = fifo_cnt_q;
        head_data_d = head_data_q;
        head_addr_d = head_addr_q;
        tail_data_d = tail_data_q;
        tail_addr_d = tail_addr_q;
`ifdef HQC_BYTEPACK_ERRCHK_EN
        w_ovf       = 1'b0;
`endif
        if (start_i) begin
            fifo_cnt_d = 2'd0;
        end else begin
            case (fifo_cnt_q)
                2'd0: begin
                    if (w_push) begin
                        head_data_d = pend_data_q;
                        head_addr_d = pend_addr_q;
                        fifo_cnt_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        head_data_d = pend_data_q;
                        head_addr_d = pend_addr_q;
                    end else if (w_push) begin
                        tail_data_d = pend_data_q;
                        tail_addr_d = pend_addr_q;
                        fifo_cnt_d  = 2'd2;
                    end else if (w_pop) begin
                        fifo_cnt_d = 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        head_data_d = tail_data_q;
                        head_addr_d = tail_addr_q;
                        if (w_push) begin
                            tail_data_d = pend_data_q;
                            tail_addr_d = pend_addr_q;
                        end else begin
                            fifo_cnt_d = 2'd1;
                        end
                    end else if (w_push) begin
                        // Full with no pop: the newest word is dropped
`ifdef HQC_BYTEPACK_ERRCHK_EN
                        w_ovf = 1'b1;
`endif
                    end
                end
            endcase
        end
    end

`ifdef HQC_BYTEPACK_ERRCHK_EN
    always_comb begin
        err_d = err_q | w_ovf | (din_valid_i && (state_q != S_PACK));
        if (start_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            lane_q      <= 3'd0;
            word_q      <= 4'd0;
            pack_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            pend_addr_q <= 4'd0;
            fifo_cnt_q  <= 2'd0;
            head_data_q <= '0;
            head_addr_q <= 4'd0;
            tail_data_q <= '0;
            tail_addr_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            pack_q      <= pack_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            pend_addr_q <= pend_addr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            head_data_q <= head_data_d;
            head_addr_q <= head_addr_d;
            tail_data_q <= tail_data_d;
            tail_addr_q <= tail_addr_d;
        end
    end

    assign dout_o       = head_data_q;
    assign dout_addr_o  = head_addr_q;
    assign dout_valid_o = (fifo_cnt_q != 2'd0);
    assign done_o       = w_done;

endmodule
`default_nettype wire
